// File: rtl/strip_result_drain_if.sv
// Strip drain bus: start/base request, conv handshake,
// strip memory read port and frame buffer write port.
interface strip_result_drain_if;
  logic               start;
  logic        [7:0]  strip_row_base;
  logic               conv_done;
  logic        [12:0] strip_addr;
  logic signed [22:0] strip_data;
  logic               fm_we;
  logic        [15:0] fm_addr;
  logic signed [7:0]  fm_din;
  logic               busy;
  logic               done;
  logic               err;
  logic        [15:0] sat_count;

  modport master (
    output start,
    output strip_row_base,
    output conv_done,
    output strip_data,
    input  strip_addr,
    input  fm_we,
    input  fm_addr,
    input  fm_din,
    input  busy,
    input  done,
    input  err,
    input  sat_count
  );

  modport slave (
    input  start,
    input  strip_row_base,
    input  conv_done,
    input  strip_data,
    output strip_addr,
    output fm_we,
    output fm_addr,
    output fm_din,
    output busy,
    output done,
    output err,
    output sat_count
  );
endinterface

// File: rtl/strip_result_drain.sv
// Drains a finished conv strip into the frame output buffer.
// Ports: clk, reset (async high), bus (slave): start/base in,
//   conv_done in, strip_addr/strip_data read port,
//   fm_we/fm_addr/fm_din write port, busy/done/err/sat_count.
module strip_result_drain #(
  parameter int OUT_W   = 222,
  parameter int OUT_H   = 26,
  parameter int FRAME_H = 222,
  parameter int SHIFT   = 7,
  parameter int RELU    = 1,
  parameter int RD_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  strip_result_drain_if.slave  bus
);
  localparam int N  = OUT_W * OUT_H;
  localparam int CW = $clog2(OUT_W);
  localparam logic [12:0] LAST_IDX = 13'(N - 1);
  localparam logic [7:0]  MAX_BASE = 8'(FRAME_H - OUT_H);
  localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - 1);
  localparam logic signed [23:0] RND =
    24'((1 << SHIFT) >> 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic [12:0]        r_idx;
  logic [CW-1:0]      r_col;
  logic [15:0]        r_row_off;
  logic [RD_LAT-1:0]  r_tag_v;
  logic [15:0]        r_tag_a [RD_LAT];
  logic               r_we;
  logic [15:0]        r_faddr;
  logic signed [7:0]  r_din;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [15:0]        r_sat;

  logic [15:0]        w_base_off;
  logic signed [23:0] w_ext;
  logic signed [23:0] w_sh;
  logic signed [7:0]  w_q;
  logic               w_clip;
  logic               w_out_v;

  // Frame offset of the strip's first row.
  assign w_base_off =
    {8'd0, bus.strip_row_base} * 16'(OUT_W);

  // Tag leaving the pipe lines up with strip_data.
  assign w_out_v = r_tag_v[RD_LAT-1];

  assign w_ext = {bus.strip_data[22], bus.strip_data};
  assign w_sh  = (w_ext + RND) >>> SHIFT;

  always_comb begin
    w_q    = w_sh[7:0];
    w_clip = 1'b0;
    if (RELU != 0 && w_sh < 24'sd0) begin
      w_q = 8'sd0;
    end else if (w_sh > 24'sd127) begin
      w_q    = 8'sd127;
      w_clip = 1'b1;
    end else if (w_sh < -24'sd128) begin
      w_q    = -8'sd128;
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_col     <= '0;
      r_row_off <= '0;
      r_tag_v   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_a[i] <= '0;
      end
      r_we      <= 1'b0;
      r_faddr   <= '0;
      r_din     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_sat     <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_a[i] <= r_tag_a[i-1];
      end
      r_tag_v[0] <= 1'b0;

      r_we <= w_out_v;
      if (w_out_v) begin
        r_faddr <= r_tag_a[RD_LAT-1];
        r_din   <= w_q;
        if (w_clip && r_sat != 16'hFFFF) begin
          r_sat <= r_sat + 16'd1;
        end
      end

      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.strip_row_base <= MAX_BASE) begin
              r_row_off <= w_base_off;
              r_idx     <= '0;
              r_col     <= '0;
              r_sat     <= '0;
              r_busy    <= 1'b1;
              r_state   <= ST_WAIT;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (bus.conv_done) begin
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_tag_v[0] <= 1'b1;
          r_tag_a[0] <= r_row_off + 16'(r_col);
          if (r_idx == LAST_IDX) begin
            r_state <= ST_FLUSH;
          end else begin
            r_idx <= r_idx + 13'd1;
            if (r_col == LAST_COL) begin
              r_col     <= '0;
              r_row_off <= r_row_off + 16'(OUT_W);
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // Last write leaves the pipe this cycle.
          if (r_tag_v == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.strip_addr = r_idx;
  assign bus.fm_we      = r_we;
  assign bus.fm_addr    = r_faddr;
  assign bus.fm_din     = r_din;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.sat_count  = r_sat;
endmodule

// File: tb/tb_strip_result_drain.sv
// Bench for strip_result_drain: two instances (default and
// SHIFT=0/RELU=0) share stimulus; checked against a strip model.
module tb_strip_result_drain;
  localparam int N = 5772;
  localparam int W = 222;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [7:0] base;
  logic conv;
  logic signed [22:0] mem [0:8191];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;
  bit act = 1'b0;
  int s_cyc = 0;
  int r_cyc = 0;
  int err_cyc = -10;
  int base_m = 0;
  logic [7:0] expA [N];
  logic [7:0] expB [N];
  int prefA [N];
  int prefB [N];
  int nA = 0;
  int nB = 0;
  int firstB = -1;
  int lastB = -1;
  int done_cyc = -1;
  int errp = 0;
  logic [7:0] capA [5];

  strip_result_drain_if ifa ();
  strip_result_drain_if ifb ();

  assign ifa.start = start;
  assign ifa.strip_row_base = base;
  assign ifa.conv_done = conv;
  assign ifb.start = start;
  assign ifb.strip_row_base = base;
  assign ifb.conv_done = conv;

  strip_result_drain dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  strip_result_drain #(.SHIFT(0), .RELU(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency strip memory per instance.
  always @(posedge clk) begin
    ifa.strip_data <= mem[ifa.strip_addr];
    ifb.strip_data <= mem[ifb.strip_addr];
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, a, e);
    end
  endtask

  function automatic logic [7:0] rq(input int d, input int sh,
                                    input bit relu, output bit sat);
    int t;
    t = (sh > 0) ? ((d + (1 << (sh - 1))) >>> sh) : d;
    sat = 1'b0;
    if (relu && t < 0) t = 0;
    if (t > 127) begin
      t = 127;
      sat = 1'b1;
    end else if (t < -128) begin
      t = -128;
      sat = 1'b1;
    end
    return t[7:0];
  endfunction

  task automatic prep();
    int ca = 0;
    int cb = 0;
    bit sa, sb;
    for (int k = 0; k < N; k++) begin
      expA[k] = rq(mem[k], 7, 1'b1, sa);
      expB[k] = rq(mem[k], 0, 1'b0, sb);
      ca += int'(sa);
      cb += int'(sb);
      prefA[k] = ca;
      prefB[k] = cb;
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 3))
        0: mem[k] = 23'($urandom);
        1: mem[k] = 23'(int'($urandom_range(0, 600)) - 300);
        default: mem[k] = 23'(int'($urandom_range(0, 40000)) - 20000);
      endcase
    end
  endtask

  // Model of every output on every cycle.
  always @(negedge clk) begin
    if (armed && !reset) begin
      int c, k, kk;
      bit win;
      c = cyc;
      k = c - r_cyc - 2;
      win = act && k >= 0 && k < N;
      chk("we_a", ifa.fm_we, win);
      chk("we_b", ifb.fm_we, win);
      if (win) begin
        chk("addr_a", ifa.fm_addr, base_m * W + k);
        chk("addr_b", ifb.fm_addr, base_m * W + k);
        chk("din_a", ifa.fm_din[7:0], expA[k]);
        chk("din_b", ifb.fm_din[7:0], expB[k]);
      end
      chk("done_a", ifa.done, act && c == r_cyc + N + 2);
      chk("done_b", ifb.done, act && c == r_cyc + N + 2);
      chk("busy_a", ifa.busy, act && c > s_cyc && c <= r_cyc + N + 1);
      chk("busy_b", ifb.busy, act && c > s_cyc && c <= r_cyc + N + 1);
      chk("err_a", ifa.err, c == err_cyc);
      chk("err_b", ifb.err, c == err_cyc);
      if (!act) begin
        chk("sat_a", ifa.sat_count, 0);
        chk("sat_b", ifb.sat_count, 0);
      end else if (c > s_cyc) begin
        kk = (k >= N) ? N - 1 : k;
        chk("sat_a", ifa.sat_count, (k < 0) ? 0 : prefA[kk]);
        chk("sat_b", ifb.sat_count, (k < 0) ? 0 : prefB[kk]);
      end
      if (act && c > s_cyc && c < r_cyc + N) begin
        chk("saddr_a", ifa.strip_addr, (c < r_cyc) ? 0 : c - r_cyc);
      end
    end
  end

  // Raw observations for the literal checks.
  always @(negedge clk) begin
    if (!reset) begin
      if (ifa.fm_we) begin
        if (nA < 5) capA[nA] = ifa.fm_din[7:0];
        nA++;
      end
      if (ifb.fm_we) begin
        if (nB == 0) firstB = int'(ifb.fm_addr);
        lastB = int'(ifb.fm_addr);
        nB++;
      end
      if (ifa.done) done_cyc = cyc;
      if (ifb.err) errp++;
    end
  end

  task automatic begin_strip(input int b, input int l);
    @(negedge clk);
    nA = 0;
    nB = 0;
    errp = 0;
    done_cyc = -1;
    firstB = -1;
    lastB = -1;
    base_m = b;
    prep();
    start = 1'b1;
    base = 8'(b);
    s_cyc = cyc;
    r_cyc = cyc + 2 + l;
    act = 1'b1;
    if (l > 0) conv = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (l > 0) begin
      repeat (l) @(negedge clk);
      conv = 1'b1;
    end
  endtask

  task automatic finish_strip(input bit drop, input bit dup);
    if (dup) begin
      repeat (30) @(negedge clk);
      start = 1'b1;
      base = 8'd250;
      @(negedge clk);
      start = 1'b0;
    end
    if (drop) begin
      repeat (200) @(negedge clk);
      conv = 1'b0;
      repeat (10) @(negedge clk);
      conv = 1'b1;
    end
    while (cyc < r_cyc + N + 4) @(negedge clk);
  endtask

  task automatic reject(input int b);
    @(negedge clk);
    errp = 0;
    nB = 0;
    start = 1'b1;
    base = 8'(b);
    err_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    start = 1'b0;
    base = 8'd0;
    conv = 1'b1;
    for (int k = 0; k < 8192; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", ifa.fm_we, 0);
    chk("rst_addr", ifa.fm_addr, 0);
    chk("rst_din", ifa.fm_din[7:0], 0);
    chk("rst_saddr", ifa.strip_addr, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_err", ifa.err, 0);
    chk("rst_sat", ifb.sat_count, 0);
    reset = 1'b0;
    armed = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < N; k++) mem[k] = 23'(k);
    begin_strip(0, 0);
    finish_strip(1'b0, 1'b0);
    chk("ramp0_done_lat", done_cyc - s_cyc, 5776);
    chk("ramp0_sat_b", ifb.sat_count, 5644);
    chk("ramp0_first", firstB, 0);
    chk("ramp0_last", lastB, 5771);
    chk("ramp0_count", nB, 5772);

    begin_strip(196, 0);
    finish_strip(1'b0, 1'b0);
    chk("b196_first", firstB, 43512);
    chk("b196_last", lastB, 49283);
    chk("b196_err", errp, 0);

    reject(197);
    chk("b197_err", errp, 1);
    chk("b197_we", nB, 0);

    for (int k = 0; k < N; k++) mem[k] = '0;
    mem[0] = -23'sd300;
    mem[1] = 23'sd63;
    mem[2] = 23'sd64;
    mem[3] = 23'sd16383;
    mem[4] = 23'sd16384;
    begin_strip(int'($urandom_range(0, 196)), 50);
    finish_strip(1'b0, 1'b0);
    chk("pat_din0", capA[0], 8'h00);
    chk("pat_din1", capA[1], 8'h00);
    chk("pat_din2", capA[2], 8'h01);
    chk("pat_din3", capA[3], 8'h7f);
    chk("pat_din4", capA[4], 8'h7f);
    // 16383+64 >>> 7 is 128, so it clips as well as 16384.
    chk("pat_sat_a", ifa.sat_count, 2);
    chk("pat_done_lat", done_cyc - s_cyc, 5826);

    fill_rand();
    begin_strip(int'($urandom_range(0, 196)),
                int'($urandom_range(0, 20)));
    finish_strip(1'b1, 1'b1);
    chk("rnd_err", errp, 0);
    chk("rnd_count", nA, 5772);

    fill_rand();
    begin_strip(int'($urandom_range(0, 196)), 0);
    t = 0;
    while (nA < 1000 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach", int'(nA >= 1000), 1);
    reset = 1'b1;
    act = 1'b0;
    #1;
    chk("midrst_we_a", ifa.fm_we, 0);
    chk("midrst_we_b", ifb.fm_we, 0);
    chk("midrst_busy", ifa.busy, 0);
    chk("midrst_sat", ifb.sat_count, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    fill_rand();
    begin_strip(int'($urandom_range(0, 196)),
                int'($urandom_range(1, 10)));
    finish_strip(1'b0, 1'b0);
    chk("fresh_count", nB, 5772);
    chk("fresh_sat_b", ifb.sat_count, prefB[N-1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
